aes_uart_stream: RTL
====================

// Module: aes_uart_stream
// PURPOSE
//  Multi-block successor to the single-block UART/AES bridge.
//  Takes a command header plus 1..MAX_BLOCKS plaintext/ciphertext blocks from the UART byte interface.
//  Runs each block through the AES core and streams a status byte plus all result blocks back.
//  Sits between the uart and aes instances.
//  New versus the single-block bridge: per-frame mode/key size, block count, inter-byte timeout, status byte, exact byte counts.
// PARAMETERS
//  MAX_BLOCKS      4          max blocks per frame (1..16)
//  BLOCK_BYTES     16         bytes per AES block (core width = 8*BLOCK_BYTES)
//  TIMEOUT_CYCLES  1000000    idle clocks allowed between received bytes of one frame
// PORTS
//  clock         in   1      system clock, all logic on posedge
//  reset         in   1      asynchronous, active-high
//  rx_rdy        in   1      UART has a received byte
//  rx_data       in   8      received byte
//  rx_rdy_clr    out  1      one-cycle pulse: byte consumed
//  tx_busy       in   1      UART transmitter busy
//  tx_begin      out  1      one-cycle pulse: start sending tx_data
//  tx_data       out  8      byte to transmit, stable from tx_begin until tx_busy rises
//  aes_reset     out  1      held high while idle; one-cycle low-going start per block (core restarts on fall)
//  aes_dec       out  1      1 = decrypt, 0 = encrypt
//  aes_key_size  out  3      key size code from header
//  aes_din       out  8*BLOCK_BYTES  block to core; first received byte in the MS byte
//  aes_done      in   1      core result valid (level)
//  aes_dout      in   8*BLOCK_BYTES  core result; MS byte transmitted first
//  busy          out  1      frame in progress (any state but IDLE)
//  err_timeout   out  1      sticky; set on timeout, cleared by next valid header
// BEHAVIOUR
//  Reset: state IDLE; rx_rdy_clr=0, tx_begin=0, tx_data=0, aes_reset=1, aes_din=0, aes_dec=0, aes_key_size=0, busy=0, err_timeout=0.
//  Header byte: [7]=dec, [6:3]=nblk-1, [2:0]=key size. nblk>MAX_BLOCKS or key size not in {0,1,2} -> status 0xE1, no blocks sent.
//  Response: status byte (0x00 ok, 0xE1 bad header, 0xEE timeout), then nblk*BLOCK_BYTES result bytes when ok.
//  States: IDLE -> HDR -> RX_BYTE -> AES_GO -> AES_WAIT -> TX_STATUS -> TX_BYTE -> TX_ACK -> (RX_BYTE | TX_STATUS | IDLE).
//  RX path:
//   rx_rdy sampled high -> byte captured, rx_rdy_clr pulsed next cycle.
//   rx_rdy must be seen low before the next capture, so no byte is captured twice.
//   Byte k of a block goes to aes_din[8*(BLOCK_BYTES-1-k) +: 8].
//   After byte BLOCK_BYTES-1: AES_GO drives aes_reset=0 for exactly one cycle, then AES_WAIT.
//  AES_WAIT: on aes_done=1, aes_dout is latched into an output shift register.
//   Status byte is sent only before block 0; then the block's bytes are sent.
//  TX path:
//   TX_BYTE waits for tx_busy=0, then drives tx_data and pulses tx_begin for 1 cycle.
//   TX_ACK waits for tx_busy=1, then advances.
//   Exactly BLOCK_BYTES bytes per block, never one extra.
//  After the last byte of a block: go to RX_BYTE for the next block, or to IDLE after block nblk-1.
//  Blocks are strictly sequential; bytes arriving during AES/TX stay pending in the UART and are not dropped.
//  Timeout:
//   Counter clears on every capture and runs only in RX_BYTE.
//   Reaching TIMEOUT_CYCLES-1 sets err_timeout, discards partial data, sends 0xEE, goes to IDLE.
//   The counter never runs in IDLE.
//  aes_done already high when AES_WAIT is entered is ignored; the bridge waits for the core to restart (done low) first.
//  Reset mid-frame: immediate return to reset values; partial frame discarded; no response sent.
//  Counters: byte index clog2(BLOCK_BYTES) bits, block index 4 bits, timeout 32 bits. All saturate-free, cleared on state entry.
// STRUCTURE
//  aes_uart_pkg:
//   state enum/localparams
//   STATUS_OK=8'h00, STATUS_BADHDR=8'hE1, STATUS_TIMEOUT=8'hEE
//   header field positions
//  Sub-module aes_uart_byte_shreg (parallel load, 8-bit shift-out, MS byte first) used for the TX result; the RX side assembles in place.
// TESTING
//  1. Header 0x00, 16 bytes 00..0F, core model returns ~din after 20 cycles -> tx 0x00 then FF..F0; exactly 17 tx_begin pulses.
//  2. Header 0x9A (dec, 4 blocks, key 2), 64 bytes -> aes_dec=1, aes_key_size=2, four aes_reset low pulses, 1+64 bytes back in order.
//  3. Header 0x03 (key 3) -> single byte 0xE1, busy falls, no aes_reset pulse; next valid header works.
//  4. Header 0x00, 5 bytes then silence, TIMEOUT_CYCLES=100 -> err_timeout=1, tx 0xEE, IDLE; next header clears err_timeout.
//  5. rx_rdy held high 10 cycles for one byte -> byte captured once; byte counter advances by 1.
//  6. Reset asserted mid-TX of block 1 -> tx_begin=0, aes_reset=1, busy=0 within the same cycle; a fresh frame then completes correctly.

Source files
------------

// File: rtl/aes_uart_pkg.sv
// aes_uart_pkg: shared states, status codes and header layout for the multi-block UART/AES bridge.
package aes_uart_pkg;

    typedef enum logic [2:0] {
        IDLE, HDR, RX_BYTE, AES_GO, AES_WAIT, TX_STATUS, TX_BYTE, TX_ACK
    } stateT;

    localparam logic [7:0] STATUS_OK      = 8'h00;
    localparam logic [7:0] STATUS_BADHDR  = 8'hE1;
    localparam logic [7:0] STATUS_TIMEOUT = 8'hEE;

    localparam int HDR_DEC_BIT  = 7;
    localparam int HDR_NBLK_LSB = 3;
    localparam int HDR_NBLK_W   = 4;
    localparam int HDR_KEY_LSB  = 0;
    localparam int HDR_KEY_W    = 3;

    // The header carries nblk-1, so nblk <= maxBlocks means the field is below maxBlocks.
    function automatic logic headerValid(input logic [7:0] hdr, input int maxBlocks);
        return (int'(hdr[HDR_NBLK_LSB +: HDR_NBLK_W]) < maxBlocks) &&
               (hdr[HDR_KEY_LSB +: HDR_KEY_W] <= 3'd2);
    endfunction

endpackage

// File: rtl/aes_uart_stream_if.sv
// aes_uart_stream_if: UART byte handshakes and AES core signals seen by the bridge.
interface aes_uart_stream_if #(parameter int BLOCK_BYTES = 16);
    logic                     rx_rdy;
    logic [7:0]               rx_data;
    logic                     rx_rdy_clr;
    logic                     tx_busy;
    logic                     tx_begin;
    logic [7:0]               tx_data;
    logic                     aes_reset;
    logic                     aes_dec;
    logic [2:0]               aes_key_size;
    logic [8*BLOCK_BYTES-1:0] aes_din;
    logic                     aes_done;
    logic [8*BLOCK_BYTES-1:0] aes_dout;

    modport master (
        input  rx_rdy, rx_data, tx_busy, aes_done, aes_dout,
        output rx_rdy_clr, tx_begin, tx_data, aes_reset, aes_dec, aes_key_size, aes_din
    );

    modport slave (
        output rx_rdy, rx_data, tx_busy, aes_done, aes_dout,
        input  rx_rdy_clr, tx_begin, tx_data, aes_reset, aes_dec, aes_key_size, aes_din
    );
endinterface

// File: rtl/aes_uart_byte_shreg.sv
// aes_uart_byte_shreg: parallel-load register that presents its MS byte and shifts one byte per request.
module aes_uart_byte_shreg #(
    parameter int BYTES = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               shift,
    input  logic [8*BYTES-1:0] loadData,
    output logic [7:0]         msByte
);
    logic [8*BYTES-1:0] data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) data <= '0;
        else if (load) data <= loadData;
        else if (shift) data <= data << 8;
    end

    assign msByte = data[8*BYTES-1 -: 8];
endmodule

// File: rtl/aes_uart_stream.sv
// aes_uart_stream: frames header + 1..MAX_BLOCKS blocks from the UART through the AES core
// and streams a status byte plus every result block back.
module aes_uart_stream
    import aes_uart_pkg::*;
#(
    parameter int MAX_BLOCKS     = 4,
    parameter int BLOCK_BYTES    = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                clock,
    input  logic                reset,
    aes_uart_stream_if.master   bus,
    output logic                busy,
    output logic                err_timeout
);
    localparam int IW = BLOCK_BYTES > 1 ? $clog2(BLOCK_BYTES) : 1;
    localparam logic [IW-1:0] LAST_BYTE = IW'(BLOCK_BYTES - 1);
    localparam logic [31:0]   TO_LAST   = 32'(TIMEOUT_CYCLES - 1);

    stateT state, nextState;
    logic [7:0] hdrByte, statusByte, txData, msByte;
    logic [IW-1:0] byteIdx;
    logic [3:0] blkIdx, nblkM1;
    logic [31:0] toCnt;
    logic [2:0] aesKey;
    logic [8*BLOCK_BYTES-1:0] aesDin;
    logic rxArm, rxRdyClr, txBegin, aesDec, errTimeout, statusPending, abortFrame, doneArmed;
    logic capture, timeoutHit, lastByte, lastBlock, resultLoad, txFire, txAck, hdrOk;

    // A byte is taken only once: rxArm re-arms after rx_rdy has been seen low.
    assign capture    = bus.rx_rdy && rxArm && (state == IDLE || state == RX_BYTE);
    assign timeoutHit = state == RX_BYTE && !capture && toCnt == TO_LAST;
    assign lastByte   = byteIdx == LAST_BYTE;
    assign lastBlock  = blkIdx == nblkM1;
    assign resultLoad = state == AES_WAIT && bus.aes_done && doneArmed;
    assign txFire     = state == TX_BYTE && !bus.tx_busy;
    assign txAck      = state == TX_ACK && bus.tx_busy;
    assign hdrOk      = headerValid(hdrByte, MAX_BLOCKS);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:      nextState = capture ? HDR : IDLE;
            HDR:       nextState = hdrOk ? RX_BYTE : TX_STATUS;
            RX_BYTE:   nextState = capture && lastByte ? AES_GO : timeoutHit ? TX_STATUS : RX_BYTE;
            AES_GO:    nextState = AES_WAIT;
            AES_WAIT:  nextState = resultLoad ? TX_STATUS : AES_WAIT;
            TX_STATUS: nextState = TX_BYTE;
            TX_BYTE:   nextState = txFire ? TX_ACK : TX_BYTE;
            TX_ACK:    nextState = !txAck ? TX_ACK :
                                   statusPending ? (abortFrame ? IDLE : TX_STATUS) :
                                   !lastByte ? TX_STATUS : lastBlock ? IDLE : RX_BYTE;
            default:   nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rxArm         <= 1'b1;
            rxRdyClr      <= 1'b0;
            txBegin       <= 1'b0;
            txData        <= '0;
            toCnt         <= '0;
            hdrByte       <= '0;
            statusByte    <= STATUS_OK;
            statusPending <= 1'b0;
            abortFrame    <= 1'b0;
            doneArmed     <= 1'b0;
            byteIdx       <= '0;
            blkIdx        <= '0;
            nblkM1        <= '0;
            aesDec        <= 1'b0;
            aesKey        <= '0;
            aesDin        <= '0;
            errTimeout    <= 1'b0;
        end else begin
            rxArm    <= !bus.rx_rdy || (rxArm && !capture);
            rxRdyClr <= capture;
            txBegin  <= txFire;
            toCnt    <= state == RX_BYTE && !capture ? toCnt + 32'd1 : '0;
            if (txFire) txData <= statusPending ? statusByte : msByte;
            if (state == IDLE && capture) hdrByte <= bus.rx_data;
            // A done level left over from the previous block must drop before a result is trusted.
            if (state == AES_GO) doneArmed <= 1'b0;
            if (state == AES_WAIT && !bus.aes_done) doneArmed <= 1'b1;
            if (state == HDR) begin
                byteIdx       <= '0;
                blkIdx        <= '0;
                statusPending <= 1'b1;
                abortFrame    <= !hdrOk;
                statusByte    <= hdrOk ? STATUS_OK : STATUS_BADHDR;
                if (hdrOk) begin
                    aesDec     <= hdrByte[HDR_DEC_BIT];
                    aesKey     <= hdrByte[HDR_KEY_LSB +: HDR_KEY_W];
                    nblkM1     <= hdrByte[HDR_NBLK_LSB +: HDR_NBLK_W];
                    errTimeout <= 1'b0;
                end
            end
            if (state == RX_BYTE && capture) begin
                aesDin[8*(BLOCK_BYTES-1-int'(byteIdx)) +: 8] <= bus.rx_data;
                byteIdx <= lastByte ? '0 : byteIdx + IW'(1);
            end else if (timeoutHit) begin
                errTimeout    <= 1'b1;
                statusByte    <= STATUS_TIMEOUT;
                statusPending <= 1'b1;
                abortFrame    <= 1'b1;
                aesDin        <= '0;
                byteIdx       <= '0;
            end
            if (txAck) begin
                statusPending <= 1'b0;
                if (!statusPending) begin
                    byteIdx <= lastByte ? '0 : byteIdx + IW'(1);
                    if (lastByte && !lastBlock) blkIdx <= blkIdx + 4'd1;
                end
            end
        end
    end

    aes_uart_byte_shreg #(.BYTES(BLOCK_BYTES)) txShreg (
        .clock    (clock),
        .reset    (reset),
        .load     (resultLoad),
        .shift    (txAck && !statusPending),
        .loadData (bus.aes_dout),
        .msByte   (msByte)
    );

    assign busy             = state != IDLE;
    assign err_timeout      = errTimeout;
    assign bus.rx_rdy_clr   = rxRdyClr;
    assign bus.tx_begin     = txBegin;
    assign bus.tx_data      = txData;
    assign bus.aes_reset    = state != AES_GO;
    assign bus.aes_dec      = aesDec;
    assign bus.aes_key_size = aesKey;
    assign bus.aes_din      = aesDin;
endmodule
